// File: rtl/gb_loader_pkg.sv
// Shared constants and state types for the UART ROM loader.
// GB_UART_LOADER_ACK_EN adds the TX_RESP parser state.
package gb_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_END   = 8'h02;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StLen,
        StData,
        StCsum
`ifdef GB_UART_LOADER_ACK_EN
        , StTxResp
`endif
    } parser_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/gb_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, byte_valid / ferr pulses.
module gb_uart_rx
    import gb_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       ferr_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      sync_q;
    logic            prev_q, prev_d;
    rx_state_e       st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;

    assign rx_s = sync_q[1];

    // State and datapath registers; line idles high out of reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            st_q    <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= prev_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: half a bit to the start-bit centre, then one bit per sample.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        prev_d  = rx_s;
        case (st_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !rx_s) st_d = RxStart;
            end
            RxStart: begin
                if (cnt_q == HalfEnd) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RxStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    st_d  = RxIdle;
                    if (rx_s) valid_d = 1'b1;
                    else      ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: st_d = RxIdle;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign ferr_o       = ferr_q;

endmodule

// File: rtl/gb_uart_loader.sv
// Serial ROM loader: parses sync/cmd/body/csum packets into byte writes for the
// memory controller load port. GB_UART_LOADER_ACK_EN adds an ACK/NAK transmitter.
module gb_uart_loader
    import gb_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_CLKS = 5000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic [27:0] uart_addr,
    output logic [7:0]  uart_data,
    output logic        uart_we,
    output logic        uart_load,
    output logic        load_err,
    output logic [15:0] pkt_count
);

    localparam int unsigned TmW = $clog2(TIMEOUT_CLKS);
    localparam logic [TmW-1:0] TmEnd = TmW'(TIMEOUT_CLKS - 1);

    logic       bv;
    logic [7:0] rx_byte;
    logic       ferr;

    gb_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock       (clock),
        .rst         (rst),
        .rx_i        (rx),
        .byte_valid_o(bv),
        .byte_o      (rx_byte),
        .ferr_o      (ferr)
    );

    parser_state_e  state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [19:0]    addr_sh_q, addr_sh_d;
    logic [15:0]    len_q, len_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [7:0]     xor_q, xor_d;
    logic [27:0]    addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic           we_q, we_d;
    logic           load_q, load_d;
    logic           err_q, err_d;
    logic [15:0]    pkt_q, pkt_d;
    logic [TmW-1:0] timer_q, timer_d;
    logic           in_pkt;
    logic           abort;
`ifdef GB_UART_LOADER_ACK_EN
    logic [7:0]     resp_q, resp_d;
`endif

    // Parser state and output registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            addr_sh_q <= '0;
            len_q     <= '0;
            cmd_q     <= '0;
            xor_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            pkt_q     <= '0;
            timer_q   <= '0;
`ifdef GB_UART_LOADER_ACK_EN
            resp_q    <= RESP_ACK;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_sh_q <= addr_sh_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            xor_q     <= xor_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            load_q    <= load_d;
            err_q     <= err_d;
            pkt_q     <= pkt_d;
            timer_q   <= timer_d;
`ifdef GB_UART_LOADER_ACK_EN
            resp_q    <= resp_d;
`endif
        end
    end

`ifdef GB_UART_LOADER_ACK_EN
    assign in_pkt = (state_q != StIdle) && (state_q != StTxResp);
`else
    assign in_pkt = (state_q != StIdle);
`endif

    // Next-state: timeout/framing aborts, packet decode, write strobe, address walk.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_sh_d = addr_sh_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        xor_d     = xor_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        load_d    = load_q;
        err_d     = err_q;
        pkt_d     = pkt_q;
        timer_d   = timer_q;
        abort     = 1'b0;
`ifdef GB_UART_LOADER_ACK_EN
        resp_d    = resp_q;
`endif

        // Address advances the cycle after each strobe, wrapping at 2^28.
        if (we_q) addr_d = addr_q + 28'd1;

        // An arriving byte beats an expiring timer and reloads it.
        if (!in_pkt || bv) begin
            timer_d = '0;
        end else if (timer_q == TmEnd) begin
            timer_d = '0;
            abort   = 1'b1;
        end else begin
            timer_d = timer_q + TmW'(1);
        end
        if (in_pkt && ferr) abort = 1'b1;

        case (state_q)
            StIdle: begin
                if (bv && rx_byte == SYNC_BYTE) begin
                    state_d = StCmd;
                    err_d   = 1'b0;
                    xor_d   = '0;
                end
            end
            StCmd: begin
                if (bv) begin
                    cmd_d = rx_byte;
                    xor_d = xor_q ^ rx_byte;
                    if (rx_byte == CMD_WRITE) begin
                        load_d  = 1'b1;
                        idx_d   = '0;
                        state_d = StAddr;
                    end else if (rx_byte == CMD_END) begin
                        state_d = StCsum;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StAddr: begin
                if (bv) begin
                    xor_d = xor_q ^ rx_byte;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Shift register keeps only the bits that survive into [27:0].
                        addr_d  = {addr_sh_q, rx_byte};
                        idx_d   = '0;
                        state_d = StLen;
                    end else begin
                        addr_sh_d = {addr_sh_q[11:0], rx_byte};
                    end
                end
            end
            StLen: begin
                if (bv) begin
                    xor_d = xor_q ^ rx_byte;
                    if (idx_q == 2'd0) begin
                        len_d = {8'h00, rx_byte};
                        idx_d = 2'd1;
                    end else begin
                        len_d   = {len_q[7:0], rx_byte};
                        idx_d   = '0;
                        state_d = ({len_q[7:0], rx_byte} == 16'd0) ? StCsum : StData;
                    end
                end
            end
            StData: begin
                if (bv) begin
                    xor_d  = xor_q ^ rx_byte;
                    we_d   = load_q;
                    data_d = rx_byte;
                    len_d  = len_q - 16'd1;
                    if (len_q == 16'd1) state_d = StCsum;
                end
            end
            StCsum: begin
                if (bv) begin
                    if (rx_byte == xor_q) begin
                        pkt_d = pkt_q + 16'd1;
                        if (cmd_q == CMD_END) load_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
`ifdef GB_UART_LOADER_ACK_EN
                    resp_d  = (rx_byte == xor_q) ? RESP_ACK : RESP_NAK;
                    state_d = StTxResp;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef GB_UART_LOADER_ACK_EN
            StTxResp: begin
                // Response is queued this cycle; a sync byte landing here still counts.
                state_d = StIdle;
                if (bv && rx_byte == SYNC_BYTE) begin
                    state_d = StCmd;
                    err_d   = 1'b0;
                    xor_d   = '0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (abort) begin
            err_d = 1'b1;
`ifdef GB_UART_LOADER_ACK_EN
            resp_d  = RESP_NAK;
            state_d = StTxResp;
`else
            state_d = StIdle;
`endif
        end
    end

`ifdef GB_UART_LOADER_ACK_EN
    localparam int unsigned TxCntW = $clog2(CLKS_PER_BIT);
    localparam logic [TxCntW-1:0] TxBitEnd = TxCntW'(CLKS_PER_BIT - 1);

    logic              pend_v_q;
    logic [7:0]        pend_byte_q;
    logic              tx_busy_q;
    logic [9:0]        tx_shift_q;
    logic [TxCntW-1:0] tx_cnt_q;
    logic [3:0]        tx_bits_q;

    // 8N1 transmitter with a single pending slot; a newer response overwrites it.
    always_ff @(posedge clock) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_byte_q <= '0;
            tx_busy_q   <= 1'b0;
            tx_shift_q  <= '1;
            tx_cnt_q    <= '0;
            tx_bits_q   <= '0;
        end else begin
            if (tx_busy_q) begin
                if (tx_cnt_q == TxBitEnd) begin
                    tx_cnt_q   <= '0;
                    tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    tx_bits_q  <= tx_bits_q - 4'd1;
                    if (tx_bits_q == 4'd1) tx_busy_q <= 1'b0;
                end else begin
                    tx_cnt_q <= tx_cnt_q + TxCntW'(1);
                end
            end else if (pend_v_q) begin
                tx_shift_q <= {1'b1, pend_byte_q, 1'b0};
                tx_busy_q  <= 1'b1;
                tx_bits_q  <= 4'd10;
                tx_cnt_q   <= '0;
                pend_v_q   <= 1'b0;
            end
            if (state_q == StTxResp) begin
                pend_v_q    <= 1'b1;
                pend_byte_q <= resp_q;
            end
        end
    end

    assign tx = tx_busy_q ? tx_shift_q[0] : 1'b1;
`else
    assign tx = 1'b1;
`endif

    assign uart_addr = addr_q;
    assign uart_data = data_q;
    assign uart_we   = we_q;
    assign uart_load = load_q;
    assign load_err  = err_q;
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_gb_uart_loader.sv
// Self-checking bench for gb_uart_loader: expected writes are queued as packets
// are sent and compared whenever the DUT strobes uart_we.
module tb_gb_uart_loader;

    localparam int unsigned Cpb = 16;
    localparam int unsigned Tmo = 2000;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        rx    = 1'b1;
    logic        tx;
    logic [27:0] uart_addr;
    logic [7:0]  uart_data;
    logic        uart_we;
    logic        uart_load;
    logic        load_err;
    logic [15:0] pkt_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [35:0] exp_q[$];
    logic [7:0]  body_q[$];
    logic [15:0] exp_pkt = 16'd0;

    gb_uart_loader #(
        .CLKS_PER_BIT(Cpb),
        .TIMEOUT_CLKS(Tmo)
    ) u_dut (
        .clock    (clock),
        .rst      (rst),
        .rx       (rx),
        .tx       (tx),
        .uart_addr(uart_addr),
        .uart_data(uart_data),
        .uart_we  (uart_we),
        .uart_load(uart_load),
        .load_err (load_err),
        .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 frame; stop_ok=0 forces the stop bit low.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (Cpb) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) @(posedge clock);
        end
        rx = stop_ok;
        repeat (Cpb) @(posedge clock);
        rx = 1'b1;
        repeat (Cpb) @(posedge clock);
    endtask

    // Sync, body_q, then the XOR checksum (or a forced wrong one).
    task automatic send_pkt(input logic bad, input logic [7:0] bad_val);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(8'hA5, 1'b1);
        foreach (body_q[i]) begin
            cs = cs ^ body_q[i];
            send_byte(body_q[i], 1'b1);
        end
        send_byte(bad ? bad_val : cs, 1'b1);
    endtask

    task automatic push_wr(input logic [27:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_state(input string tag, input logic ld, input logic er);
        @(negedge clock);
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_load"}, 32'(uart_load), 32'(ld));
        check_eq({tag, "_err"}, 32'(load_err), 32'(er));
        check_eq({tag, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!rst && uart_we) begin
            if (exp_q.size() == 0) begin
                check_eq("we_unexpected", {4'h0, uart_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check_eq("we_addr", 32'(uart_addr), 32'(e[35:8]));
                check_eq("we_data", 32'(uart_data), 32'(e[7:0]));
                check_eq("we_load", 32'(uart_load), 32'd1);
            end
        end
    end

    initial begin
        repeat (4) @(posedge clock);
        @(negedge clock);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_addr", 32'(uart_addr), 32'd0);
        check_eq("rst_data", 32'(uart_data), 32'd0);
        check_eq("rst_we", 32'(uart_we), 32'd0);
        check_eq("rst_load", 32'(uart_load), 32'd0);
        check_eq("rst_err", 32'(load_err), 32'd0);
        check_eq("rst_pkt", 32'(pkt_count), 32'd0);
        @(posedge clock);
        rst = 1'b0;
        repeat (20) @(posedge clock);

        // Three-byte write at 0x100
        body_q = {8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        push_wr(28'h0000100, 8'h11);
        push_wr(28'h0000101, 8'h22);
        push_wr(28'h0000102, 8'h33);
        send_pkt(1'b0, 8'h00);
        exp_pkt++;
        check_state("p1", 1'b1, 1'b0);

        // Region 1 write with wrong checksum: write lands, error flagged
        body_q = {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAB};
        push_wr(28'h1000000, 8'hAB);
        send_pkt(1'b1, 8'h00);
        check_state("badcs", 1'b1, 1'b1);

        // END closes the session
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        @(negedge clock);
        check_eq("end_load_held", 32'(uart_load), 32'd1);
        check_eq("end_err_cleared", 32'(load_err), 32'd0);
        send_byte(8'h02, 1'b1);
        exp_pkt++;
        check_state("end", 1'b0, 1'b0);

        // Address wrap at 2^28
        body_q = {8'h01, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h5A, 8'hC3};
        push_wr(28'hFFFFFFF, 8'h5A);
        push_wr(28'h0000000, 8'hC3);
        send_pkt(1'b0, 8'h00);
        exp_pkt++;
        check_state("wrap", 1'b1, 1'b0);

        // Framing error on the second data byte aborts the packet
        push_wr(28'h0000200, 8'h77);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b0);
        check_state("ferr", 1'b1, 1'b1);

        // Parser back in IDLE: a fresh packet is accepted
        body_q = {8'h01, 8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 8'h99};
        push_wr(28'h2000010, 8'h99);
        send_pkt(1'b0, 8'h00);
        exp_pkt++;
        check_state("recover", 1'b1, 1'b0);

        // Inter-byte timeout after the LEN bytes
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        repeat (Tmo - 100) @(posedge clock);
        @(negedge clock);
        check_eq("tmo_not_yet", 32'(load_err), 32'd0);
        repeat (200) @(posedge clock);
        check_state("tmo", 1'b1, 1'b1);

        // Timed-out parser is idle: END is accepted
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_pkt++;
        check_state("tmo_end", 1'b0, 1'b0);

        // Reset in the middle of a WRITE header
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clock);
        check_eq("mid_load", 32'(uart_load), 32'd1);
        @(posedge clock);
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("mrst_tx", 32'(tx), 32'd1);
        check_eq("mrst_addr", 32'(uart_addr), 32'd0);
        check_eq("mrst_data", 32'(uart_data), 32'd0);
        check_eq("mrst_we", 32'(uart_we), 32'd0);
        check_eq("mrst_load", 32'(uart_load), 32'd0);
        check_eq("mrst_err", 32'(load_err), 32'd0);
        check_eq("mrst_pkt", 32'(pkt_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
